// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes and controller states.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for writes,
// lane selection plus sign/zero extension for loads, and the alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  rdByte;
    logic [15:0] rdHalf;

    assign rdByte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign rdHalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store data is replicated across lanes so only the byte enables pick the target lane.
    always_comb begin
        be_o       = 4'b0000;
        wword_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & rdByte[7]}}, rdByte};
            end
            SZ_HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{~unsigned_i & rdHalf[15]}}, rdHalf};
                misalign_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                be_o       = 4'b1111;
                wword_o    = wdata_i;
                rdata_o    = rword_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_bytelane.sv
// MEM-stage data memory: requests are captured at the accept edge and performed on the
// following edge, which also registers the response. Reset re-runs a word-per-cycle clear.
module data_mem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e      state_q, state_d;
    logic [IDX_W-1:0] initCnt_q, initCnt_d;

    logic        reqValid_q;
    logic        reqWe_q;
    logic        reqUns_q;
    logic [1:0]  reqSize_q;
    logic [31:0] reqAddr_q;
    logic [31:0] reqWdata_q;

    logic        rspValid_q, rspValid_d;
    logic        rspErr_q, rspErr_d;
    logic [31:0] rspRdata_q, rspRdata_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] reqIdx;
    logic [31:0]      rdWord;
    logic [3:0]       laneBe;
    logic [31:0]      laneWdata;
    logic [31:0]      laneRdata;
    logic             misalign;
    logic             illegalSize;
    logic             outOfRange;
    logic             accessErr;

    logic             wrEn;
    logic [IDX_W-1:0] wrIdx;
    logic [3:0]       wrBe;
    logic [31:0]      wrData;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        case (state_q)
            ST_INIT: begin
                initCnt_d = initCnt_q + 1'b1;
                if (&initCnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;

    // An accept sampled together with reset low is dropped, as is anything already captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reqValid_q <= 1'b0;
        end else begin
            reqValid_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            reqWe_q    <= req_we;
            reqUns_q   <= req_unsigned;
            reqSize_q  <= req_size;
            reqAddr_q  <= req_addr;
            reqWdata_q <= req_wdata;
        end
    end

    assign reqIdx      = reqAddr_q[IDX_W+1:2];
    assign rdWord      = mem_q[reqIdx];
    assign illegalSize = !(reqSize_q inside {SZ_BYTE, SZ_HALF, SZ_WORD});
    assign outOfRange  = CHECK_RANGE && ((reqAddr_q >> (IDX_W + 2)) != 32'd0);
    assign accessErr   = illegalSize | misalign | outOfRange;

    dmem_lane_align u_align (
        .size_i     (reqSize_q),
        .addr_lo_i  (reqAddr_q[1:0]),
        .unsigned_i (reqUns_q),
        .wdata_i    (reqWdata_q),
        .rword_i    (rdWord),
        .be_o       (laneBe),
        .wword_o    (laneWdata),
        .rdata_o    (laneRdata),
        .misalign_o (misalign)
    );

    always_comb begin
        wrEn   = 1'b0;
        wrIdx  = reqIdx;
        wrBe   = laneBe;
        wrData = laneWdata;
        if (state_q == ST_INIT) begin
            wrEn   = 1'b1;
            wrIdx  = initCnt_q;
            wrBe   = 4'b1111;
            wrData = '0;
        end else if (reqValid_q && reqWe_q && !accessErr) begin
            wrEn = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wrEn) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wrBe[lane]) begin
                    mem_q[wrIdx][8*lane +: 8] <= wrData[8*lane +: 8];
                end
            end
        end
    end

    always_comb begin
        rspValid_d = reqValid_q;
        rspErr_d   = reqValid_q & accessErr;
        rspRdata_d = '0;
        if (reqValid_q && !reqWe_q && !accessErr) begin
            rspRdata_d = laneRdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rspRdata_q <= rspRdata_d;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_err   = rspErr_q;
    assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Drives a range-checked and a wrapping instance with the same traffic and checks both
// against a byte-array reference model, plus hand-computed directed expectations.
module tb_data_mem_bytelane;
    import dmem_pkg::*;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        readyC, readyW;
    logic        rspValidC, rspValidW;
    logic [31:0] rdataC, rdataW;
    logic        errC, errW;
    logic        initBusyC, initBusyW;

    int testsRun;
    int testsFailed;

    logic        gotValidC;
    logic [31:0] gotRdC, gotRdW;
    logic        gotErrC, gotErrW;

    data_mem_bytelane #(.DEPTH_WORDS(DEPTH), .CHECK_RANGE(1'b1)) dutC (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(readyC),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspValidC),
        .rsp_rdata(rdataC), .rsp_err(errC), .init_busy(initBusyC)
    );

    data_mem_bytelane #(.DEPTH_WORDS(DEPTH), .CHECK_RANGE(1'b0)) dutW (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(readyW),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspValidW),
        .rsp_rdata(rdataW), .rsp_err(errW), .init_busy(initBusyW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: byte-addressed view of each instance (0 = range-checked, 1 = wrapping).
    logic [31:0] mdlMem [2][DEPTH];
    bit          mKnown = 1'b0;
    bit          mInit  = 1'b1;
    int          mCnt;
    bit          pendValid;
    bit          pendWe;
    bit   [1:0]  pendSize;
    bit          pendUns;
    bit   [31:0] pendAddr;
    bit   [31:0] pendWdata;
    bit          expValid;
    bit   [31:0] expRd [2];
    bit          expErr [2];

    function automatic void modelAccess(input int inst, input bit we, input bit [1:0] size,
                                        input bit uns, input bit [31:0] addr, input bit [31:0] wdata,
                                        output bit [31:0] rd, output bit err);
        int unsigned nBytes;
        int unsigned off;
        int unsigned idx;
        bit [31:0]   val;
        nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (addr % nBytes != 0) || (inst == 0 && addr >= 4 * DEPTH);
        rd  = 32'd0;
        if (!err) begin
            idx = (addr / 4) % DEPTH;
            off = addr % 4;
            if (we) begin
                for (int k = 0; k < int'(nBytes); k++)
                    mdlMem[inst][idx][8*(off+k) +: 8] = wdata[8*k +: 8];
            end else begin
                val = 32'd0;
                for (int k = 0; k < int'(nBytes); k++)
                    val = val | (32'(mdlMem[inst][idx][8*(off+k) +: 8]) << (8 * k));
                if (nBytes < 4 && !uns && val[8*nBytes-1])
                    val = val - (32'd1 << (8 * nBytes));
                rd = val;
            end
        end
    endfunction

    always @(posedge clk) begin : modelStep
        bit readyNow;
        if (!rst_n) begin
            mKnown    = 1'b1;
            mInit     = 1'b1;
            mCnt      = 0;
            pendValid = 1'b0;
            expValid  = 1'b0;
        end else if (mKnown) begin
            readyNow = !mInit;
            expValid = pendValid;
            if (pendValid) begin
                for (int i = 0; i < 2; i++)
                    modelAccess(i, pendWe, pendSize, pendUns, pendAddr, pendWdata, expRd[i], expErr[i]);
            end
            if (mInit) begin
                mdlMem[0][mCnt] = 32'd0;
                mdlMem[1][mCnt] = 32'd0;
                mCnt++;
                if (mCnt == DEPTH) mInit = 1'b0;
            end
            pendValid = readyNow && req_valid;
            pendWe    = req_we;
            pendSize  = req_size;
            pendUns   = req_unsigned;
            pendAddr  = req_addr;
            pendWdata = req_wdata;
        end
    end

    always @(negedge clk) begin
        if (mKnown) begin
            checkOutput("initBusyC", 32'(initBusyC), 32'(mInit));
            checkOutput("initBusyW", 32'(initBusyW), 32'(mInit));
            checkOutput("readyC", 32'(readyC), 32'(!mInit));
            checkOutput("readyW", 32'(readyW), 32'(!mInit));
            checkOutput("rspValidC", 32'(rspValidC), 32'(expValid));
            checkOutput("rspValidW", 32'(rspValidW), 32'(expValid));
            if (expValid) begin
                checkOutput("rspRdataC", rdataC, expRd[0]);
                checkOutput("rspRdataW", rdataW, expRd[1]);
                checkOutput("rspErrC", 32'(errC), 32'(expErr[0]));
                checkOutput("rspErrW", 32'(errW), 32'(expErr[1]));
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic captureResponse();
        @(posedge clk);
        #1;
        gotValidC = rspValidC;
        gotRdC    = rdataC;
        gotErrC   = errC;
        gotRdW    = rdataW;
        gotErrW   = errW;
    endtask

    task automatic doOp(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(we, size, uns, addr, wdata);
        captureResponse();
    endtask

    task automatic waitInit();
        int cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!initBusyC) break;
        end
        checkOutput("initLength", cycles, DEPTH);
        checkOutput("readyAfterInit", 32'(readyC), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] addr;
        int          r;
        testsRun     = 0;
        testsFailed  = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", 32'(initBusyC), 32'd1);
        checkOutput("resetReady", 32'(readyC), 32'd0);
        checkOutput("resetValid", 32'(rspValidC), 32'd0);
        checkOutput("resetRdata", rdataC, 32'd0);
        checkOutput("resetErr", 32'(errC), 32'd0);
        rst_n = 1'b1;
        waitInit();

        for (int a = 0; a < 64; a += 4) begin
            doOp(1'b0, SZ_WORD, 1'b0, 32'(a), 32'd0);
            checkOutput("clearedWord", gotRdC, 32'd0);
        end

        doOp(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8081_7F01);
        checkOutput("swRdataZero", gotRdC, 32'd0);
        doOp(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'd0);
        checkOutput("lb10", gotRdC, 32'h0000_0001);
        doOp(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'd0);
        checkOutput("lb11", gotRdC, 32'h0000_007F);
        doOp(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'd0);
        checkOutput("lb12", gotRdC, 32'hFFFF_FF81);
        doOp(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0);
        checkOutput("lb13", gotRdC, 32'hFFFF_FF80);
        doOp(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0);
        checkOutput("lbu13", gotRdC, 32'h0000_0080);

        doOp(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344);
        doOp(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_BEEF);
        doOp(1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);
        checkOutput("lwAfterSh", gotRdC, 32'hBEEF_3344);
        doOp(1'b0, SZ_HALF, 1'b0, 32'h22, 32'd0);
        checkOutput("lh22", gotRdC, 32'hFFFF_BEEF);
        doOp(1'b0, SZ_HALF, 1'b1, 32'h22, 32'd0);
        checkOutput("lhu22", gotRdC, 32'h0000_BEEF);

        doOp(1'b0, SZ_WORD, 1'b0, 32'h21, 32'd0);
        checkOutput("lwMisalignErr", 32'(gotErrC), 32'd1);
        checkOutput("lwMisalignRdata", gotRdC, 32'd0);
        doOp(1'b1, SZ_HALF, 1'b0, 32'h23, 32'h0000_FFFF);
        checkOutput("shMisalignErr", 32'(gotErrC), 32'd1);
        doOp(1'b1, 2'b11, 1'b0, 32'h20, 32'd0);
        checkOutput("illegalSizeErr", 32'(gotErrC), 32'd1);
        doOp(1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);
        checkOutput("unchangedAfterErr", gotRdC, 32'hBEEF_3344);

        doOp(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEAD_BEEF);
        checkOutput("rangeErrChecked", 32'(gotErrC), 32'd1);
        checkOutput("rangeErrWrapped", 32'(gotErrW), 32'd0);
        doOp(1'b0, SZ_WORD, 1'b0, 32'h0, 32'd0);
        checkOutput("word0Checked", gotRdC, 32'd0);
        checkOutput("word0Wrapped", gotRdW, 32'hDEAD_BEEF);

        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h1234_5678);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0);
        captureResponse();
        checkOutput("rawValid", 32'(gotValidC), 32'd1);
        checkOutput("rawData", gotRdC, 32'h1234_5678);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0) addr = $urandom();
            else if (r == 1) addr = 32'h40 + $urandom_range(0, 63);
            else addr = 32'($urandom_range(0, 63));
            r = $urandom_range(0, 9);
            req_size = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : 2'b11;
            if ($urandom_range(0, 3) != 0) begin
                if (req_size == SZ_HALF) addr[0] = 1'b0;
                if (req_size == SZ_WORD) addr[1:0] = 2'b00;
            end
            req_valid    = ($urandom_range(0, 3) != 0);
            req_we       = $urandom_range(0, 1) == 1;
            req_unsigned = $urandom_range(0, 1) == 1;
            req_addr     = addr;
            req_wdata    = $urandom();
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstSuppressValid", 32'(rspValidC), 32'd0);
        checkOutput("rstRestartBusy", 32'(initBusyC), 32'd1);
        rst_n = 1'b1;
        waitInit();
        doOp(1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0);
        checkOutput("clearedAfterRestart", gotRdC, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/data_mem_bytelane.md
# data_mem_bytelane

Parametrised data memory for the MIPS pipeline's MEM stage with byte, halfword and word loads and stores. Loads are sign- or zero-extended, and writes use per-lane byte enables. Accesses go through a valid/ready request port and return a registered one-cycle response. Misaligned and out-of-range accesses are reported instead of silently performed. After reset, a hardware init sequencer clears the array one word per cycle.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; must be a power of two ≥ 4. IDX_W = $clog2(DEPTH_WORDS).
- CHECK_RANGE, 1: 1 = address bits [31:IDX_W+2] nonzero raises an error; 0 = those bits are ignored (address wraps modulo 4·DEPTH_WORDS bytes).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block accepts a request this cycle.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned, input, 1: zero-extend on load (LBU/LHU); ignored for word loads and for stores.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid, output, 1: one-cycle pulse carrying the response to an accepted request.
- rsp_rdata, output, 32: extended load data; 0 for stores and errors.
- rsp_err, output, 1: misaligned, out-of-range or illegal size.
- init_busy, output, 1: clear sequence in progress.

## Operation
- State machine INIT → IDLE. Reset forces INIT, clears the word counter to 0, and drops rsp_valid. Any in-flight response is discarded.
- In INIT:
  - One word is written with 0 per cycle, at index 0 up to DEPTH_WORDS-1.
  - init_busy=1 and req_ready=0.
  - After the last word, the FSM moves to IDLE.
- In IDLE: req_ready=1 every cycle, with no backpressure. The accept condition is req_valid & req_ready.
- Error conditions, any of which applies:
  - req_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - CHECK_RANGE=1 and addr[31:IDX_W+2]≠0.
- On error, no array write occurs, rsp_err=1 and rsp_rdata=0.
- Word index is addr[IDX_W+1:2]. Memory is little-endian.
- Store byte lanes:
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
  - Word: all four lanes ← wdata.
  - Unselected lanes are unchanged.
- Load extraction:
  - Byte: lane addr[1:0], extended from bit 7.
  - Half: lanes {addr[1],1:0}, extended from bit 15.
  - Word: returned as stored.
  - Extension is zero if req_unsigned=1, otherwise sign.
- A store returns rsp_valid=1, rsp_err as computed, rsp_rdata=0.

## Timing
- Reset values: req_ready=0, init_busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Init length: clk edges 1..DEPTH_WORDS after rst_n is sampled high each clear one word. init_busy and req_ready change at edge DEPTH_WORDS, becoming 0 and 1 respectively.
- Latency: a request accepted at edge N gives rsp_valid/rsp_rdata/rsp_err valid from edge N+1 for exactly one cycle. No response follows a cycle with no accept.
- Throughput: one request per cycle.
- Read after write to the same word on back-to-back cycles returns the new data, because the store commits at edge N and the load reads at edge N+1.
- No combinational path from req_* to rsp_*; all rsp outputs are registered.
- rst_n low during INIT or IDLE restarts the clear from word 0 on release.

## Structure
- Shared package dmem_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The state encoding ST_INIT/ST_IDLE.
- Sub-module dmem_lane_align is purely combinational. Inputs are size, addr[1:0], unsigned, wdata and the raw read word. Outputs are the 4-bit byte-enable, the lane-shifted store word, the extended load data and the misaligned flag.
- The top level holds the array, init counter, FSM, range check and response registers.

## Test plan
- Reset release with DEPTH_WORDS=16 → init_busy=1 for 16 cycles and req_ready=1 at cycle 16. An LW of each address 0x00..0x3C then returns 0.
- SW 0x8081_7F01 @0x10, then LB @0x10..0x13 → 0x0000_0001, 0x0000_007F, 0xFFFF_FF81, 0xFFFF_FF80. LBU @0x13 → 0x0000_0080.
- SH 0xBEEF @0x22 onto word 0x1122_3344 @0x20 → LW @0x20 = 0xBEEF_3344. LH @0x22 = 0xFFFF_BEEF. LHU @0x22 = 0x0000_BEEF.
- LW @0x21, SH @0x23 and size=11 → rsp_err=1 and rsp_rdata=0, with array contents unchanged on a subsequent read.
- Out-of-range address 0x40 with DEPTH_WORDS=16:
  - CHECK_RANGE=1: SW 0xDEAD_BEEF @0x40 → rsp_err=1, and word 0 stays 0.
  - CHECK_RANGE=0: the same store writes word 0.
- Back-to-back SW 0x1234_5678 @0x8 then LW @0x8 → response 0x1234_5678 on the cycle after the load. Asserting rst_n=0 one cycle after a load accept suppresses that load's rsp_valid and restarts INIT.
